// File: rtl/test_rr_src_arbiter_if.sv
// test_rr_src_arbiter_if: requester-side and sink-side val/rdy channels plus done flags
// slave modport faces the arbiter, master modport faces the sources/sink
interface test_rr_src_arbiter_if #(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 8
);
  localparam int iw = $clog2(p_nreqs);
  logic [p_nreqs-1:0]             in_val;
  logic [p_nreqs-1:0]             in_rdy;
  logic [p_nreqs-1:0]             in_done;
  logic [p_nreqs*p_msg_nbits-1:0] in_msg;
  logic                           out_val;
  logic                           out_rdy;
  logic [iw+p_msg_nbits-1:0]      out_msg;
  logic                           all_done;
  modport master (output in_val, in_msg, in_done, out_rdy, input in_rdy, out_val, out_msg, all_done);
  modport slave  (input in_val, in_msg, in_done, out_rdy, output in_rdy, out_val, out_msg, all_done);
endinterface

// File: rtl/test_rr_src_arbiter.sv
// test_rr_src_arbiter: round-robin merge of tagged test-source channels into one buffered output
// Define TEST_RR_ARB_STATS_EN to add the xfer_count/stall_count output counters.
module test_rr_src_arbiter #(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 8,
  parameter int p_burst     = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  test_rr_src_arbiter_if.slave io
`ifdef TEST_RR_ARB_STATS_EN
  ,
  output logic [31:0]          xfer_count,
  output logic [31:0]          stall_count
`endif
);
  localparam int iw = $clog2(p_nreqs);
  localparam int cw = $clog2(p_burst) + 1;
  typedef enum logic {ARB, LOCK} state_t;
  state_t                    state_q, state_d;
  logic [iw-1:0]             ptr_q, ptr_d, owner_q, owner_d, w, g;
  logic [cw-1:0]             cnt_q, cnt_d;
  logic                      out_val_q, out_val_d;
  logic [iw+p_msg_nbits-1:0] out_msg_q, out_msg_d;
  logic [p_msg_nbits-1:0]    g_msg;
  logic                      found, granted, can_acc, xfer;
  // descending scan so the closest requester at or after ptr wins
  always_comb begin
    w = '0;
    found = 1'b0;
    for (int k = p_nreqs - 1; k >= 0; k--)
      if (io.in_val[ptr_q + iw'(k)]) begin
        w = ptr_q + iw'(k);
        found = 1'b1;
      end
  end
  always_comb begin
    g_msg = '0;
    for (int i = 0; i < p_nreqs; i++)
      if (g == iw'(i)) g_msg = io.in_msg[i*p_msg_nbits +: p_msg_nbits];
  end
  assign can_acc   = !out_val_q | io.out_rdy;
  assign g         = state_q == LOCK ? owner_q : w;
  assign granted   = state_q == LOCK | found;
  assign xfer      = granted & can_acc & io.in_val[g];
  assign io.in_rdy = (reset_n & granted & can_acc) ? p_nreqs'(1) << g : '0;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    out_val_d = xfer | (out_val_q & !io.out_rdy);
    out_msg_d = xfer ? {g, g_msg} : out_msg_q;
    if (state_q == ARB) begin
      if (xfer && p_burst == 1) ptr_d = w + 1'b1;
      else if (xfer) begin
        owner_d = w;
        cnt_d   = cw'(1);
        state_d = LOCK;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == cw'(p_burst)) begin
        ptr_d   = owner_q + 1'b1;
        state_d = ARB;
      end
    end else if (can_acc) begin
      ptr_d   = owner_q + 1'b1;
      state_d = ARB;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
    end
  assign io.out_val  = out_val_q;
  assign io.out_msg  = out_msg_q;
  assign io.all_done = &io.in_done & !out_val_q;
`ifdef TEST_RR_ARB_STATS_EN
  logic [31:0] xfer_count_q, xfer_count_d, stall_count_q, stall_count_d;
  always_comb begin
    xfer_count_d  = xfer_count_q + {31'b0, out_val_q & io.out_rdy};
    stall_count_d = stall_count_q + {31'b0, out_val_q & !io.out_rdy};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      xfer_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_test_rr_src_arbiter.sv
// tb_test_rr_src_arbiter: directed scoreboard bench for a p_burst=1 and a p_burst=3 arbiter
module tb_test_rr_src_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] q1[$];
  logic [9:0] q3[$];
  logic [7:0] m[4] = '{8'hC0, 8'hB1, 8'hA5, 8'hD3};
  always #5 clk = ~clk;
  test_rr_src_arbiter_if #(.p_nreqs(4), .p_msg_nbits(8)) a ();
  test_rr_src_arbiter_if #(.p_nreqs(4), .p_msg_nbits(8)) b ();
`ifdef TEST_RR_ARB_STATS_EN
  logic [31:0] xc1, sc1, xc3, sc3;
`endif
  test_rr_src_arbiter #(.p_nreqs(4), .p_msg_nbits(8), .p_burst(1)) u1 (
    .clk(clk), .reset_n(reset_n), .io(a.slave)
`ifdef TEST_RR_ARB_STATS_EN
    , .xfer_count(xc1), .stall_count(sc1)
`endif
  );
  test_rr_src_arbiter #(.p_nreqs(4), .p_msg_nbits(8), .p_burst(3)) u3 (
    .clk(clk), .reset_n(reset_n), .io(b.slave)
`ifdef TEST_RR_ARB_STATS_EN
    , .xfer_count(xc3), .stall_count(sc3)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] em(input int i, input logic [7:0] d);
    logic [1:0] t;
    t = i[1:0];
    return {t, d};
  endfunction
  always @(negedge clk)
    if (reset_n && a.out_val && a.out_rdy) begin
      if (q1.size() == 0) check("u1 unexpected output", {22'b0, a.out_msg}, 32'hFFFF_FFFF);
      else check("u1 out_msg", {22'b0, a.out_msg}, {22'b0, q1.pop_front()});
    end
  always @(negedge clk)
    if (reset_n && b.out_val && b.out_rdy) begin
      if (q3.size() == 0) check("u3 unexpected output", {22'b0, b.out_msg}, 32'hFFFF_FFFF);
      else check("u3 out_msg", {22'b0, b.out_msg}, {22'b0, q3.pop_front()});
    end
  initial begin
    a.in_val = 4'b0100; a.in_done = '0; a.out_rdy = 1'b1;
    a.in_msg = {m[3], m[2], m[1], m[0]};
    b.in_val = '0; b.in_done = '0; b.out_rdy = 1'b1;
    b.in_msg = {m[3], m[2], m[1], m[0]};
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_val", {31'b0, a.out_val}, 0);
    check("reset out_msg", {22'b0, a.out_msg}, 0);
    check("reset in_rdy", {28'b0, a.in_rdy}, 0);
    check("reset all_done", {31'b0, a.all_done}, 0);
    // single requester 2, then ptr=3 must favour req 3 over req 0
    cyc(); reset_n = 1'b1;
    q1.push_back(em(2, 8'hA5));
    @(negedge clk) check("single in_rdy", {28'b0, a.in_rdy}, 4'b0100);
    cyc(); a.in_val = 4'b1001;
    q1.push_back(em(3, m[3]));
    @(negedge clk) check("ptr3 in_rdy", {28'b0, a.in_rdy}, 4'b1000);
    cyc();
    q1.push_back(em(0, m[0]));
    @(negedge clk) check("wrap in_rdy", {28'b0, a.in_rdy}, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      cyc(); a.in_val = 4'b1111;
      q1.push_back(em((1 + k) % 4, m[(1 + k) % 4]));
      @(negedge clk);
      check("rr in_rdy", {28'b0, a.in_rdy}, 32'(1) << ((1 + k) % 4));
      check("rr out_val", {31'b0, a.out_val}, 1);
    end
    cyc(); a.in_val = '0;
    cyc();
    @(negedge clk) check("rr drained", q1.size(), 0);
    // backpressure with 0x3C held in the buffer
    cyc(); a.in_val = 4'b0001; a.in_msg = {m[3], m[2], 8'h77, 8'h3C};
    q1.push_back(em(0, 8'h3C));
    cyc(); a.in_val = 4'b0010; a.out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_msg", {22'b0, a.out_msg}, {22'b0, em(0, 8'h3C)});
      check("bp out_val", {31'b0, a.out_val}, 1);
      check("bp in_rdy", {28'b0, a.in_rdy}, 0);
      cyc();
    end
    a.out_rdy = 1'b1;
    q1.push_back(em(1, 8'h77));
    @(negedge clk) check("bp refill in_rdy", {28'b0, a.in_rdy}, 4'b0010);
    cyc(); a.in_val = '0;
    @(negedge clk) check("bp refill out_val", {31'b0, a.out_val}, 1);
`ifdef TEST_RR_ARB_STATS_EN
    check("stall_count", sc1, 5);
`endif
    // async reset discards buffer; done flag
    cyc(); a.out_rdy = 1'b0; a.in_val = 4'b0100;
    cyc(); a.in_val = '0; a.in_done = 4'b1111;
    @(negedge clk) check("done with buffer", {31'b0, a.all_done}, 0);
    cyc(); a.in_val = 4'b0100;
    #1 reset_n = 1'b0;
    #1;
    check("async out_val", {31'b0, a.out_val}, 0);
    check("async in_rdy", {28'b0, a.in_rdy}, 0);
    cyc(); reset_n = 1'b1; a.in_val = '0; a.out_rdy = 1'b1;
    @(negedge clk) check("all_done", {31'b0, a.all_done}, 1);
    a.in_done = 4'b0111;
    #1 check("not all_done", {31'b0, a.all_done}, 0);
    // burst lock on u3
    for (int k = 0; k < 7; k++) begin
      cyc(); b.in_val = 4'b0011;
      q3.push_back(em((k / 3) % 2, m[(k / 3) % 2]));
      @(negedge clk) check("burst in_rdy", {28'b0, b.in_rdy}, 32'(1) << ((k / 3) % 2));
    end
    cyc(); b.in_val = '0;
    @(negedge clk) check("burst lock in_rdy", {28'b0, b.in_rdy}, 4'b0001);
    cyc();
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1;
    // early release: one idle cycle, then req 1
    b.in_val = 4'b0011;
    q3.push_back(em(0, m[0]));
    @(negedge clk) check("early A in_rdy", {28'b0, b.in_rdy}, 4'b0001);
    cyc(); b.in_val = 4'b0010;
    @(negedge clk) check("early B in_rdy", {28'b0, b.in_rdy}, 4'b0001);
    cyc();
    q3.push_back(em(1, m[1]));
    @(negedge clk);
    check("early C in_rdy", {28'b0, b.in_rdy}, 4'b0010);
    check("early C gap", {31'b0, b.out_val}, 0);
    cyc(); b.in_val = '0;
    @(negedge clk) check("early D out_val", {31'b0, b.out_val}, 1);
    cyc();
    @(negedge clk);
    check("q1 drained", q1.size(), 0);
    check("q3 drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/test_rr_src_arbiter.md
# test_rr_src_arbiter

Round-robin arbiter that shares one latency-insensitive val/rdy test channel among `p_nreqs` random-delay test sources. Each source's message is tagged with its index and passed to a single downstream sink or DUT input through a one-entry output buffer. An optional burst lock keeps a grant on one source for up to `p_burst` consecutive transfers. The block also combines the per-source `done` flags into one end-of-test flag.

## Interface
Parameters:
- `p_nreqs`, 4, number of requesters; ≥2, power of two
- `p_msg_nbits`, 8, payload width per requester
- `p_burst`, 1, maximum consecutive transfers per grant; 1 disables locking

Ports:
- `clk`  in  1  clock; one clock domain, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `in_val`  in  p_nreqs  per-requester valid
- `in_rdy`  out  p_nreqs  per-requester ready
- `in_msg`  in  p_nreqs*p_msg_nbits  requester i occupies bits [i*p_msg_nbits +: p_msg_nbits]
- `in_done`  in  p_nreqs  per-source done flags
- `out_val`  out  1  buffered message valid
- `out_rdy`  in  1  sink ready
- `out_msg`  out  clog2(p_nreqs)+p_msg_nbits  {source index, payload}
- `all_done`  out  1  all sources done and buffer empty

## Operation
- **Buffer:** one register holding `out_val` and `out_msg`. It can accept a message (`can_acc`) when `!out_val | out_rdy`, so a refill can happen in the same cycle as a drain.
- **Priority pointer:** `ptr`, clog2(p_nreqs) bits, reset 0.
  - The winner `w` is the first i with `in_val[i]` high, searching ptr, ptr+1, … and wrapping modulo p_nreqs.
- **FSM states:** ARB (reset state) and LOCK. LOCK holds the registers `owner` and `cnt` (clog2(p_burst)+1 bits).
- **ARB:**
  - `in_rdy[w] = can_acc` and all other `in_rdy` are 0. No winner means all `in_rdy` are 0.
  - On a transfer from w, the buffer loads {w, payload}.
  - If p_burst==1: ptr ← w+1, stay in ARB.
  - Else: owner ← w, cnt ← 1, go to LOCK.
- **LOCK:**
  - `in_rdy[owner] = can_acc` and all other `in_rdy` are 0.
  - On a transfer: cnt ← cnt+1. If cnt+1 == p_burst, then ptr ← owner+1 and go to ARB.
  - If `can_acc` is high and `in_val[owner]` is low, release: ptr ← owner+1, go to ARB. No transfer occurs in that cycle and other requesters are not granted until the next cycle.
  - While `can_acc` is low, LOCK holds with no release.
- **Index arithmetic:** ptr+1 wraps modulo p_nreqs, so the maximum index wraps to 0.
- **Priority mask:** `in_val` bits of other requesters that arrive during LOCK are ignored until the return to ARB.
- **Done:** `all_done = &in_done & !out_val`, combinational from registered state plus inputs.
- **Reset:**
  - Reset values: `out_val`=0, `out_msg`=0, ptr=0, state=ARB, owner=0, cnt=0.
  - A buffered message is discarded when reset asserts mid-operation.
  - `in_rdy` is 0 while `reset_n` is low.

## Timing
- Latency: a message accepted in cycle t appears on `out_val`/`out_msg` in cycle t+1.
- Throughput: one transfer per cycle while `out_rdy` is held high.
- `in_rdy` depends combinationally on `in_val` and `out_rdy`. No output depends combinationally on `in_msg`.
- Requesters must hold `in_msg` stable while `in_val` is high and `in_rdy` is low.
- `out_msg` is stable while `out_val` is high and `out_rdy` is low.
- Simultaneous drain and fill: the buffer takes the new message and `out_val` stays 1.

## Configuration
- `TEST_RR_ARB_STATS_EN` adds two things:
  - Output port `xfer_count` [31:0]: counts transfers on the output channel (`out_val & out_rdy`), resets to 0, wraps at 2^32.
  - Output port `stall_count` [31:0]: counts cycles where `out_val & !out_rdy`.
- Without `TEST_RR_ARB_STATS_EN`, neither port nor its counters exist, and the behaviour is otherwise identical.

## Test plan
- **Single requester:** p_nreqs=4, p_burst=1; only req 2 valid with msg 0xA5, `out_rdy`=1 → `out_msg`={2'd2,8'hA5} one cycle later; ptr becomes 3.
- **Round-robin fairness:** all 4 requesters valid continuously, `out_rdy`=1, p_burst=1 → output indices 0,1,2,3,0,… with one transfer per cycle and no gaps.
- **Burst lock:** p_burst=3; reqs 0 and 1 always valid → indices 0,0,0,1,1,1,0.
- **Early release:** p_burst=3; req 0 drops valid after 1 transfer → one idle cycle, then req 1 is granted; ptr=1 after release.
- **Backpressure:** `out_rdy`=0 for 5 cycles with msg 0x3C buffered → `out_msg` held at 0x3C, all `in_rdy`=0. When `out_rdy` rises, the drain and the next fill happen in the same cycle. With `TEST_RR_ARB_STATS_EN`, `stall_count`=5.
- **Async reset and done:**
  - Assert `reset_n`=0 between clock edges with `out_val`=1 → `out_val`=0 immediately.
  - After release, drive all `in_done`=1 with the buffer empty → `all_done`=1.
  - While a message is still buffered, `all_done`=0.
